alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the 32-bit combinational ALU.
- Width is generic in 4-bit slices.
- Adds shift and multiply ops that iterate over several cycles.
- Adds a valid/ready handshake on operand input and on result output so the datapath controller can stall.
- Sits between the register-file read ports and the writeback mux.

Parameters:
- WIDTH, 32, datapath width in bits; multiple of 4, range 8..64.
- SHAMT_W, $clog2(WIDTH), width of the shift amount taken from B.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous and active-high.
- IN_VALID  in  1  operands and OP are valid this cycle.
- IN_READY  out  1  block accepts a new operation.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B; shift ops use B[SHAMT_W-1:0].
- OP  in  4  opcode; common::alu_op_t.
- C_IN  in  1  carry in; ADD only.
- OUT_VALID  out  1  result and flags valid.
- OUT_READY  in  1  consumer takes the result.
- OUT  out  WIDTH  result; low half for MUL.
- OUT_HI  out  WIDTH  high half of the MUL product; 0 for all other ops.
- Z  out  1  OUT == 0.
- C  out  1  carry / shift-out / MUL overflow.
- N  out  1  OUT[WIDTH-1].
- V  out  1  signed overflow.

Behaviour:
- **Reset:**
  - RST high at any edge forces state IDLE.
  - OUT, OUT_HI, Z, C, N, V and OUT_VALID all go to 0.
  - An in-flight op is discarded with no result produced.
- **States:** IDLE, ITER, HOLD.
- **Accept:**
  - IN_READY = (state == IDLE).
  - An op is accepted when IN_VALID && IN_READY at the edge; A, B, OP and C_IN are captured.
- **Single-cycle ops** (ADD, SUB, AND, OR, XOR, NOT, NOP0, NOP1):
  - Result is registered at the accept edge; go to HOLD.
  - OUT_VALID is high the cycle after accept (latency 1).
- **Iterative ops** (SHL, SHR, SAR, MUL):
  - Go to ITER and load the cycle counter.
  - Shifts move 1 bit per cycle for B[SHAMT_W-1:0] cycles.
  - Shift amount 0 goes straight to HOLD (latency 1, OUT = A, C = 0).
  - MUL is unsigned shift-add over exactly WIDTH cycles, so latency = WIDTH + 1.
  - Counter reaches 0, then HOLD.
- **HOLD:**
  - OUT_VALID = 1; outputs stay stable until OUT_READY.
  - OUT_VALID && OUT_READY returns to IDLE next cycle.
  - No back-to-back accept in the same cycle as the handoff, so throughput is at most 1 op per 2 cycles.
- **Operand capture:** IN_VALID while not IN_READY is ignored; the inputs are not sampled.
- **Result and flag rules:**
  - ADD: OUT = A + B + C_IN mod 2^WIDTH; C = carry out; V = signed overflow.
  - SUB: computed as A + ~B + 1, ignoring C_IN. C = carry out, where 1 means no borrow. V = signed overflow.
  - AND/OR/XOR: bitwise; C = V = 0.
  - NOT: ~A; C = V = 0.
  - NOP0/NOP1: OUT = 0; C = V = 0.
  - SHL/SHR: logical shifts, zero fill.
  - SAR: arithmetic shift; sign fill from A[WIDTH-1].
  - Shifts: C = last bit shifted out; V = 0.
  - MUL: {OUT_HI, OUT} = A * B, unsigned; C = V = (OUT_HI != 0).
  - Z and N are computed from OUT only, never from OUT_HI.
- **Opcode range:** opcodes 12..15 are reserved. They behave as NOP (OUT = 0, latency 1).
- **Slice carry:** ADD/SUB carry is produced per 4-bit slice with lookahead in RTL. The implementation does not depend on an external lookahead ROM.

Decomposition:
- **Package common:**
  - Add typedef alu_op_t as a 4-bit enum.
  - Existing 3-bit encodings are kept as values 0..7, zero-extended.
  - Add ALU_SHL=8, ALU_SHR=9, ALU_SAR=10, ALU_MUL=11.
  - Add the alu_state_t enum for IDLE/ITER/HOLD.
- **Sub-module alu_comb:**
  - Purely combinational, WIDTH-parametrised.
  - Computes the single-cycle ops and the C/V flags.
  - Instantiated once by alu_seq.
  - Shift/MUL iteration and the handshake live in alu_seq.

Test Plan (WIDTH=32 unless stated):
- **ADD with carry:** A=FFFFFFFF, B=00000001, C_IN=0. Expect OUT=0, Z=1, C=1, V=0, OUT_VALID exactly 1 cycle after accept.
- **SUB overflow:** A=80000000, B=00000001. Expect OUT=7FFFFFFF, C=1, V=1, N=0. Also A=0, B=1: OUT=FFFFFFFF, C=0, N=1.
- **Arithmetic shift:** SAR with A=80000010, B=4. Expect OUT=F8000001, C=0, latency 5 cycles. SHL with B=0: OUT=A, latency 1.
- **Multiply:** MUL with A=FFFFFFFF, B=2. Expect OUT=FFFFFFFE, OUT_HI=1, C=V=1, OUT_VALID at cycle 33. Repeat with WIDTH=8: A=0F, B=11 gives OUT=FF, OUT_HI=0, latency 9.
- **Backpressure:**
  - Hold OUT_READY=0 for 5 cycles after OUT_VALID: OUT and flags stay stable and IN_READY=0.
  - A new op presented meanwhile is not captured.
  - OUT_READY=1 returns the block to IDLE next cycle.
- **Reset mid-MUL:**
  - Assert RST at cycle 10 of a MUL: next cycle all outputs are 0, OUT_VALID=0, IN_READY=1.
  - The following ADD 2+3 gives OUT=5.

Source files
------------

// File: rtl/common.sv
// Shared opcode and sequencer state types for the ALU.
// Opcodes 0..7 keep the original 3-bit encodings, zero-extended.
package common;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOT  = 4'd5,
        ALU_NOP0 = 4'd6,
        ALU_NOP1 = 4'd7,
        ALU_SHL  = 4'd8,
        ALU_SHR  = 4'd9,
        ALU_SAR  = 4'd10,
        ALU_MUL  = 4'd11
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_HOLD = 2'd2
    } alu_state_t;

    function automatic logic op_is_shift(input logic [3:0] op);
        return (op == ALU_SHL) || (op == ALU_SHR) || (op == ALU_SAR);
    endfunction

    function automatic logic op_is_mul(input logic [3:0] op);
        return (op == ALU_MUL);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational single-cycle ALU ops with flags.
// Adder uses 4-bit lookahead slices chained slice to slice.
module alu_comb
    import common::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             c_in,
    output logic [WIDTH-1:0] y,
    output logic             c,
    output logic             v
);

    localparam int NS = WIDTH / 4;

    logic             sub;
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] sum;
    logic [NS:0]      sc;
    logic             ovf;

    assign sub   = (op == ALU_SUB);
    assign bx    = sub ? ~b : b;
    assign g     = a & bx;
    assign p     = a ^ bx;
    assign sc[0] = sub ? 1'b1 : c_in;

    for (genvar s = 0; s < NS; s++) begin : g_slice
        logic [3:0] gs;
        logic [3:0] ps;
        logic [4:0] cs;
        logic       gg;
        logic       pg;

        assign gs    = g[4*s +: 4];
        assign ps    = p[4*s +: 4];
        assign cs[0] = sc[s];
        assign cs[1] = gs[0] | (ps[0] & cs[0]);
        assign cs[2] = gs[1] | (ps[1] & gs[0])
                     | (ps[1] & ps[0] & cs[0]);
        assign cs[3] = gs[2] | (ps[2] & gs[1])
                     | (ps[2] & ps[1] & gs[0])
                     | (ps[2] & ps[1] & ps[0] & cs[0]);
        assign gg    = gs[3] | (ps[3] & gs[2])
                     | (ps[3] & ps[2] & gs[1])
                     | (ps[3] & ps[2] & ps[1] & gs[0]);
        assign pg    = &ps;
        assign cs[4] = gg | (pg & cs[0]);

        assign sum[4*s +: 4] = ps ^ cs[3:0];
        assign sc[s+1]       = cs[4];
    end

    assign ovf = (a[WIDTH-1] == bx[WIDTH-1])
              && (sum[WIDTH-1] != a[WIDTH-1]);

    // Select the single-cycle result; shifts pass A for the zero-amount case.
    always_comb begin
        y = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB: begin
                y = sum;
                c = sc[NS];
                v = ovf;
            end
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_NOT: y = ~a;
            ALU_SHL, ALU_SHR, ALU_SAR: y = a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes on operands and result.
// Shifts step one bit per cycle; MUL is WIDTH-cycle shift-add.
module alu_seq
    import common::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       OP,
    input  logic             C_IN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT,
    output logic [WIDTH-1:0] OUT_HI,
    output logic             Z,
    output logic             C,
    output logic             N,
    output logic             V
);

    localparam int CNT_W = SHAMT_W + 1;

    alu_state_t state_q;
    alu_state_t state_d;

    logic [3:0]       op_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_hi_q;
    logic             z_q;
    logic             c_q;
    logic             n_q;
    logic             v_q;

    logic [SHAMT_W-1:0] shamt;
    logic               accept;
    logic               go_iter;
    logic               last_step;

    logic [WIDTH-1:0] comb_y;
    logic             comb_c;
    logic             comb_v;

    logic [WIDTH-1:0] lo_nx;
    logic [WIDTH-1:0] hi_nx;
    logic [WIDTH:0]   mul_sum;
    logic             co_nx;

    logic [WIDTH-1:0] fin_hi;
    logic             fin_c;
    logic             fin_v;

    assign shamt     = B[SHAMT_W-1:0];
    assign accept    = IN_VALID && (state_q == ST_IDLE);
    assign go_iter   = op_is_mul(OP)
                    || (op_is_shift(OP) && (shamt != '0));
    assign last_step = (cnt_q == CNT_W'(1));

    alu_comb #(
        .WIDTH(WIDTH)
    ) u_comb (
        .a    (A),
        .b    (B),
        .op   (OP),
        .c_in (C_IN),
        .y    (comb_y),
        .c    (comb_c),
        .v    (comb_v)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        case (state_q)
            ST_IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    state_d = go_iter ? ST_ITER : ST_HOLD;
                end
            end
            ST_ITER: begin
                if (last_step) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // One iteration step of the active shift or multiply.
    always_comb begin
        lo_nx   = lo_q;
        hi_nx   = hi_q;
        co_nx   = 1'b0;
        mul_sum = '0;
        case (op_q)
            ALU_SHL: begin
                lo_nx = {lo_q[WIDTH-2:0], 1'b0};
                co_nx = lo_q[WIDTH-1];
            end
            ALU_SHR: begin
                lo_nx = {1'b0, lo_q[WIDTH-1:1]};
                co_nx = lo_q[0];
            end
            ALU_SAR: begin
                lo_nx = {lo_q[WIDTH-1], lo_q[WIDTH-1:1]};
                co_nx = lo_q[0];
            end
            ALU_MUL: begin
                mul_sum = {1'b0, hi_q}
                        + (lo_q[0] ? {1'b0, mcand_q} : '0);
                hi_nx   = mul_sum[WIDTH:1];
                lo_nx   = {mul_sum[0], lo_q[WIDTH-1:1]};
            end
            default: lo_nx = lo_q;
        endcase
    end

    // Final-step flags: MUL reports high-half nonzero, shifts the last bit out.
    always_comb begin
        fin_hi = '0;
        fin_c  = co_nx;
        fin_v  = 1'b0;
        if (op_is_mul(op_q)) begin
            fin_hi = hi_nx;
            fin_c  = |hi_nx;
            fin_v  = |hi_nx;
        end
    end

    // Operand capture, iteration registers and result registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            op_q     <= '0;
            mcand_q  <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            out_hi_q <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= OP;
                        mcand_q <= A;
                        hi_q    <= '0;
                        lo_q    <= op_is_mul(OP) ? B : A;
                        cnt_q   <= op_is_mul(OP)
                                 ? CNT_W'(WIDTH)
                                 : {1'b0, shamt};
                        if (!go_iter) begin
                            out_q    <= comb_y;
                            out_hi_q <= '0;
                            z_q      <= (comb_y == '0);
                            n_q      <= comb_y[WIDTH-1];
                            c_q      <= comb_c;
                            v_q      <= comb_v;
                        end
                    end
                end
                ST_ITER: begin
                    lo_q  <= lo_nx;
                    hi_q  <= hi_nx;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (last_step) begin
                        out_q    <= lo_nx;
                        out_hi_q <= fin_hi;
                        z_q      <= (lo_nx == '0);
                        n_q      <= lo_nx[WIDTH-1];
                        c_q      <= fin_c;
                        v_q      <= fin_v;
                    end
                end
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign OUT    = out_q;
    assign OUT_HI = out_hi_q;
    assign Z      = z_q;
    assign C      = c_q;
    assign N      = n_q;
    assign V      = v_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=32 and WIDTH=8.
// Expected results come from an arithmetic reference model.
module tb_alu_seq;
    import common::*;

    typedef struct {
        logic [63:0] out;
        logic [63:0] hi;
        logic        z;
        logic        c;
        logic        n;
        logic        v;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        iv, ir, ov, ordy, cin;
    logic        z, c, n, v;
    logic [31:0] a, b, out, out_hi;
    logic [3:0]  op;

    logic        iv8, ir8, ov8, ordy8, cin8;
    logic        z8, c8, n8, v8;
    logic [7:0]  a8, b8, out8, out_hi8;
    logic [3:0]  op8;

    int checks   = 0;
    int failures = 0;

    alu_seq #(.WIDTH(32)) dut (
        .CLK(clk), .RST(rst),
        .IN_VALID(iv), .IN_READY(ir),
        .A(a), .B(b), .OP(op), .C_IN(cin),
        .OUT_VALID(ov), .OUT_READY(ordy),
        .OUT(out), .OUT_HI(out_hi),
        .Z(z), .C(c), .N(n), .V(v)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .CLK(clk), .RST(rst),
        .IN_VALID(iv8), .IN_READY(ir8),
        .A(a8), .B(b8), .OP(op8), .C_IN(cin8),
        .OUT_VALID(ov8), .OUT_READY(ordy8),
        .OUT(out8), .OUT_HI(out_hi8),
        .Z(z8), .C(c8), .N(n8), .V(v8)
    );

    function automatic exp_t model(input int o, input logic [63:0] xi,
                                   input logic [63:0] yi, input logic ci,
                                   input int w);
        exp_t        e;
        logic [63:0] m, x, y, xs;
        logic [64:0] s;
        logic [127:0] p;
        int          sh;
        m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        x = xi & m;
        y = yi & m;
        sh = int'(y[5:0]) % w;
        s = '0;
        e.out = '0; e.hi = '0; e.c = 0; e.v = 0; e.lat = 1;
        case (o)
            0: begin
                s = {1'b0, x} + {1'b0, y} + 65'(ci);
                e.out = s[63:0] & m;
                e.c = s[w];
                e.v = (x[w-1] == y[w-1]) && (e.out[w-1] != x[w-1]);
            end
            1: begin
                s = {1'b0, x} + {1'b0, (~y) & m} + 65'd1;
                e.out = s[63:0] & m;
                e.c = s[w];
                e.v = (x[w-1] != y[w-1]) && (e.out[w-1] != x[w-1]);
            end
            2: e.out = x & y;
            3: e.out = x | y;
            4: e.out = x ^ y;
            5: e.out = ~x & m;
            8: begin
                e.out = (x << sh) & m;
                e.c = (sh != 0) ? x[w-sh] : 1'b0;
                e.lat = sh + 1;
            end
            9: begin
                e.out = x >> sh;
                e.c = (sh != 0) ? x[sh-1] : 1'b0;
                e.lat = sh + 1;
            end
            10: begin
                xs = x[w-1] ? (x | ~m) : x;
                e.out = 64'($signed(xs) >>> sh) & m;
                e.c = (sh != 0) ? xs[sh-1] : 1'b0;
                e.lat = sh + 1;
            end
            11: begin
                p = 128'(x) * 128'(y);
                e.out = p[63:0] & m;
                e.hi = 64'(p >> w) & m;
                e.c = (e.hi != 0);
                e.v = e.c;
                e.lat = w + 1;
            end
            default: e.out = '0;
        endcase
        e.z = (e.out == 0);
        e.n = e.out[w-1];
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic ci,
                         output int lat);
        op = o; a = x; b = y; cin = ci; iv = 1'b1;
        tick();
        iv = 1'b0;
        lat = 1;
        while (!ov && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic issue8(input logic [3:0] o, input logic [7:0] x,
                          input logic [7:0] y, output int lat);
        op8 = o; a8 = x; b8 = y; cin8 = 1'b0; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        lat = 1;
        while (!ov8 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_out();
        ordy = 1'b1; ordy8 = 1'b1;
        tick();
        ordy = 1'b0; ordy8 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({ov, ir, out, out_hi, z, c, n, v} !== {1'b0, 1'b1, 64'd0, 4'd0}) begin
            failures++;
            $display("FAIL reset32 got ov=%b ir=%b out=%h hi=%h zcnv=%b%b%b%b want ov=0 ir=1 all 0",
                     ov, ir, out, out_hi, z, c, n, v);
        end
        checks++;
        if ({ov8, ir8, out8, out_hi8, z8, c8, n8, v8} !== {1'b0, 1'b1, 16'd0, 4'd0}) begin
            failures++;
            $display("FAIL reset8 got ov=%b ir=%b out=%h hi=%h want ov=0 ir=1 all 0",
                     ov8, ir8, out8, out_hi8);
        end
    endtask

    task automatic test_add_carry();
        int lat;
        issue(4'(ALU_ADD), 32'hFFFF_FFFF, 32'h1, 1'b0, lat);
        checks++;
        if (lat !== 1) begin
            failures++;
            $display("FAIL add_latency got %0d want 1", lat);
        end
        checks++;
        if ({out, z, c, n, v} !== {32'h0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL add_carry got out=%h zcnv=%b%b%b%b want 00000000 zcnv=1100",
                     out, z, c, n, v);
        end
        release_out();
    endtask

    task automatic test_sub();
        int lat;
        issue(4'(ALU_SUB), 32'h8000_0000, 32'h1, 1'b1, lat);
        checks++;
        if ({out, c, v, n} !== {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL sub_ovf got out=%h c=%b v=%b n=%b want 7fffffff c=1 v=1 n=0",
                     out, c, v, n);
        end
        release_out();
        issue(4'(ALU_SUB), 32'h0, 32'h1, 1'b0, lat);
        checks++;
        if ({out, c, n, v, lat} !== {32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 32'd1}) begin
            failures++;
            $display("FAIL sub_borrow got out=%h c=%b n=%b v=%b lat=%0d want ffffffff c=0 n=1 v=0 lat=1",
                     out, c, n, v, lat);
        end
        release_out();
    endtask

    task automatic test_shift();
        int lat;
        logic [31:0] x;
        issue(4'(ALU_SAR), 32'h8000_0010, 32'd4, 1'b0, lat);
        checks++;
        if ({out, c, v, lat} !== {32'hF800_0001, 1'b0, 1'b0, 32'd5}) begin
            failures++;
            $display("FAIL sar got out=%h c=%b v=%b lat=%0d want f8000001 c=0 v=0 lat=5",
                     out, c, v, lat);
        end
        release_out();
        x = $urandom | 32'h1;
        issue(4'(ALU_SHL), x, 32'd0, 1'b0, lat);
        checks++;
        if ({out, out_hi, c, lat} !== {x, 32'd0, 1'b0, 32'd1}) begin
            failures++;
            $display("FAIL shl_zero got out=%h hi=%h c=%b lat=%0d want %h 0 c=0 lat=1",
                     out, out_hi, c, lat, x);
        end
        release_out();
    endtask

    task automatic test_mul();
        int lat;
        issue(4'(ALU_MUL), 32'hFFFF_FFFF, 32'd2, 1'b0, lat);
        checks++;
        if ({out, out_hi, c, v, lat} !== {32'hFFFF_FFFE, 32'd1, 1'b1, 1'b1, 32'd33}) begin
            failures++;
            $display("FAIL mul32 got out=%h hi=%h c=%b v=%b lat=%0d want fffffffe 1 c=1 v=1 lat=33",
                     out, out_hi, c, v, lat);
        end
        release_out();
    endtask

    task automatic test_mul8();
        int lat;
        exp_t e;
        logic [7:0] x, y;
        issue8(4'(ALU_MUL), 8'h0F, 8'h11, lat);
        checks++;
        if ({out8, out_hi8, c8, v8, lat} !== {8'hFF, 8'h00, 1'b0, 1'b0, 32'd9}) begin
            failures++;
            $display("FAIL mul8 got out=%h hi=%h c=%b v=%b lat=%0d want ff 00 c=0 v=0 lat=9",
                     out8, out_hi8, c8, v8, lat);
        end
        release_out();
        for (int i = 0; i < 6; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            e = model(11, 64'(x), 64'(y), 1'b0, 8);
            issue8(4'(ALU_MUL), x, y, lat);
            checks++;
            if ({out8, out_hi8, z8, c8, n8, v8, lat} !==
                {e.out[7:0], e.hi[7:0], e.z, e.c, e.n, e.v, e.lat}) begin
                failures++;
                $display("FAIL mul8_rand %h*%h got %h:%h zcnv=%b%b%b%b lat=%0d want %h:%h zcnv=%b%b%b%b lat=%0d",
                         x, y, out_hi8, out8, z8, c8, n8, v8, lat,
                         e.hi[7:0], e.out[7:0], e.z, e.c, e.n, e.v, e.lat);
            end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        exp_t e;
        exp_t e2;
        logic [31:0] x, y;
        x = $urandom;
        y = $urandom;
        e = model(4, 64'(x), 64'(y), 1'b0, 32);
        issue(4'(ALU_XOR), x, y, 1'b0, lat);
        op = 4'(ALU_ADD); a = 32'd7; b = 32'd9; cin = 1'b0; iv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({ov, ir, out, out_hi, z, c, n, v} !==
                {1'b1, 1'b0, e.out[31:0], 32'd0, e.z, e.c, e.n, e.v}) begin
                failures++;
                $display("FAIL hold_stable cyc=%0d got ov=%b ir=%b out=%h want ov=1 ir=0 out=%h",
                         i, ov, ir, out, e.out[31:0]);
            end
            tick();
        end
        iv = 1'b0;
        release_out();
        checks++;
        if ({ov, ir} !== 2'b01) begin
            failures++;
            $display("FAIL handoff got ov=%b ir=%b want ov=0 ir=1", ov, ir);
        end
        e2 = model(0, 64'd7, 64'd9, 1'b0, 32);
        issue(4'(ALU_ADD), 32'd7, 32'd9, 1'b0, lat);
        checks++;
        if ({out, lat} !== {e2.out[31:0], 32'd1}) begin
            failures++;
            $display("FAIL after_hold got out=%h lat=%0d want %h lat=1",
                     out, lat, e2.out[31:0]);
        end
        release_out();
    endtask

    task automatic test_reset_mid_mul();
        int lat;
        op = 4'(ALU_MUL); a = 32'h1234_5678; b = 32'h9ABC_DEF1;
        cin = 1'b0; iv = 1'b1;
        tick();
        iv = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({ov, ir, out, out_hi, z, c, n, v} !== {1'b0, 1'b1, 64'd0, 4'd0}) begin
            failures++;
            $display("FAIL reset_mid_mul got ov=%b ir=%b out=%h hi=%h zcnv=%b%b%b%b want ov=0 ir=1 all 0",
                     ov, ir, out, out_hi, z, c, n, v);
        end
        issue(4'(ALU_ADD), 32'd2, 32'd3, 1'b0, lat);
        checks++;
        if ({out, out_hi, lat} !== {32'd5, 32'd0, 32'd1}) begin
            failures++;
            $display("FAIL add_after_reset got out=%h hi=%h lat=%0d want 5 0 lat=1",
                     out, out_hi, lat);
        end
        release_out();
    endtask

    task automatic test_random();
        int lat;
        int o;
        exp_t e;
        logic [31:0] x, y;
        logic ci;
        for (int i = 0; i < 60; i++) begin
            o = int'($urandom_range(0, 15));
            x = $urandom;
            y = $urandom;
            ci = 1'($urandom);
            if ((i % 4) == 0) x[31] = 1'b1;
            e = model(o, 64'(x), 64'(y), ci, 32);
            issue(4'(o), x, y, ci, lat);
            checks++;
            if ({out, out_hi, z, c, n, v, lat} !==
                {e.out[31:0], e.hi[31:0], e.z, e.c, e.n, e.v, e.lat}) begin
                failures++;
                $display("FAIL rand op=%0d a=%h b=%h ci=%b got %h:%h zcnv=%b%b%b%b lat=%0d want %h:%h zcnv=%b%b%b%b lat=%0d",
                         o, x, y, ci, out_hi, out, z, c, n, v, lat,
                         e.hi[31:0], e.out[31:0], e.z, e.c, e.n, e.v, e.lat);
            end
            release_out();
        end
    endtask

    initial begin
        rst = 1'b1;
        iv = 1'b0; ordy = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0;
        iv8 = 1'b0; ordy8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; cin8 = 1'b0;
        test_reset();
        test_add_carry();
        test_sub();
        test_shift();
        test_mul();
        test_mul8();
        test_backpressure();
        test_reset_mid_mul();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
